// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with forwarding, operand mux and load-use stall (option macro FWD_EN)
module id_ex_operand_stage #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 6
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_stall,
    input  logic           i_flush,
    input  logic           i_valid,
    input  logic [DW-1:0]  i_rs_data,
    input  logic [DW-1:0]  i_rt_data,
    input  logic [AW-1:0]  i_rs_addr,
    input  logic [AW-1:0]  i_rt_addr,
    input  logic [AW-1:0]  i_rd_addr,
    input  logic [15:0]    i_imm,
    input  logic [4:0]     i_shamt,
    input  logic [OPW-1:0] i_ALUOp,
    input  logic           i_alu_src_imm,
    input  logic           i_imm_zext,
    input  logic [1:0]     i_shift_mode,
    input  logic           i_reg_write,
    input  logic           i_mem_read,
    input  logic           i_mem_write,
    input  logic           i_exmem_reg_write,
    input  logic [AW-1:0]  i_exmem_rd,
    input  logic [DW-1:0]  i_exmem_result,
    input  logic           i_memwb_reg_write,
    input  logic [AW-1:0]  i_memwb_rd,
    input  logic [DW-1:0]  i_memwb_result,
    output logic           o_valid,
    output logic [DW-1:0]  o_srcA,
    output logic [DW-1:0]  o_srcB,
    output logic [OPW-1:0] o_ALUOp,
    output logic [DW-1:0]  o_store_data,
    output logic [AW-1:0]  o_rd_addr,
    output logic           o_reg_write,
    output logic           o_mem_read,
    output logic           o_mem_write,
    output logic           o_hazard_stall
);
    logic [DW-1:0] rs_data, rt_data, fa, fb, ext;
    logic [15:0]   imm;
    logic [4:0]    shamt;
    logic          alu_src_imm, imm_zext;
    logic [1:0]    shift_mode;
    logic          ld_hit, rs_hit, rt_hit;
`ifdef FWD_EN
    logic [AW-1:0] rs_addr, rt_addr;
`endif

    // pipeline register: reset/flush load a bubble, stall holds, otherwise capture ID
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            o_valid     <= 1'b0;
            rs_data     <= '0;
            rt_data     <= '0;
            o_rd_addr   <= '0;
            imm         <= '0;
            shamt       <= '0;
            o_ALUOp     <= '0;
            alu_src_imm <= 1'b0;
            imm_zext    <= 1'b0;
            shift_mode  <= '0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
`ifdef FWD_EN
            rs_addr     <= '0;
            rt_addr     <= '0;
`endif
        end else if (!i_stall) begin
            o_valid     <= i_valid;
            rs_data     <= i_rs_data;
            rt_data     <= i_rt_data;
            o_rd_addr   <= i_rd_addr;
            imm         <= i_imm;
            shamt       <= i_shamt;
            o_ALUOp     <= i_ALUOp;
            alu_src_imm <= i_alu_src_imm;
            imm_zext    <= i_imm_zext;
            shift_mode  <= i_shift_mode;
            o_reg_write <= i_reg_write & i_valid;
            o_mem_read  <= i_mem_read & i_valid;
            o_mem_write <= i_mem_write & i_valid;
`ifdef FWD_EN
            rs_addr     <= i_rs_addr;
            rt_addr     <= i_rt_addr;
`endif
        end
    end

    // operand selection: forwarding (when built in), immediate extension, shift source swap
    always_comb begin
`ifdef FWD_EN
        fa = (i_exmem_reg_write && i_exmem_rd == rs_addr && rs_addr != '0) ? i_exmem_result :
             (i_memwb_reg_write && i_memwb_rd == rs_addr && rs_addr != '0) ? i_memwb_result : rs_data;
        fb = (i_exmem_reg_write && i_exmem_rd == rt_addr && rt_addr != '0) ? i_exmem_result :
             (i_memwb_reg_write && i_memwb_rd == rt_addr && rt_addr != '0) ? i_memwb_result : rt_data;
`else
        fa = rs_data;
        fb = rt_data;
`endif
        ext          = imm_zext ? {{(DW-16){1'b0}}, imm} : {{(DW-16){imm[15]}}, imm};
        o_srcA       = (shift_mode == 2'b01 || shift_mode == 2'b10) ? fb : fa;
        o_srcB       = shift_mode == 2'b01 ? {{(DW-5){1'b0}}, shamt} :
                       shift_mode == 2'b10 ? {{(DW-5){1'b0}}, fa[4:0]} :
                       alu_src_imm ? ext : fb;
        o_store_data = fb;
    end

    // stall request: load-use always; without forwarding also any producer still in flight
    always_comb begin
        ld_hit = o_valid && o_mem_read && o_rd_addr != '0 &&
                 (o_rd_addr == i_rs_addr || o_rd_addr == i_rt_addr);
`ifdef FWD_EN
        rs_hit = 1'b0;
        rt_hit = 1'b0;
`else
        rs_hit = i_rs_addr != '0 && ((o_reg_write && i_rs_addr == o_rd_addr) ||
                                     (i_exmem_reg_write && i_rs_addr == i_exmem_rd));
        rt_hit = i_rt_addr != '0 && ((o_reg_write && i_rt_addr == o_rd_addr) ||
                                     (i_exmem_reg_write && i_rt_addr == i_exmem_rd));
`endif
        o_hazard_stall = !i_reset && i_valid && (ld_hit || rs_hit || rt_hit);
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;
    logic        clk = 0, rst, stall, flush, valid;
    logic [31:0] rs_d, rt_d, ex_res, wb_res;
    logic [4:0]  rs_a, rt_a, rd_a, shamt, ex_rd, wb_rd;
    logic [15:0] imm;
    logic [5:0]  op;
    logic        src_imm, zext, rw, mr, mw, ex_rw, wb_rw;
    logic [1:0]  mode;
    logic        o_valid, o_rw, o_mr, o_mw, o_hz;
    logic [31:0] o_a, o_b, o_sd;
    logic [5:0]  o_op;
    logic [4:0]  o_rd;
    int checks = 0, errors = 0;

    id_ex_operand_stage dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_rs_data(rs_d), .i_rt_data(rt_d), .i_rs_addr(rs_a), .i_rt_addr(rt_a), .i_rd_addr(rd_a),
        .i_imm(imm), .i_shamt(shamt), .i_ALUOp(op), .i_alu_src_imm(src_imm), .i_imm_zext(zext),
        .i_shift_mode(mode), .i_reg_write(rw), .i_mem_read(mr), .i_mem_write(mw),
        .i_exmem_reg_write(ex_rw), .i_exmem_rd(ex_rd), .i_exmem_result(ex_res),
        .i_memwb_reg_write(wb_rw), .i_memwb_rd(wb_rd), .i_memwb_result(wb_res),
        .o_valid(o_valid), .o_srcA(o_a), .o_srcB(o_b), .o_ALUOp(o_op), .o_store_data(o_sd),
        .o_rd_addr(o_rd), .o_reg_write(o_rw), .o_mem_read(o_mr), .o_mem_write(o_mw),
        .o_hazard_stall(o_hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid = 0; rs_d = 0; rt_d = 0; rs_a = 0; rt_a = 0; rd_a = 0; imm = 0; shamt = 0;
        op = 0; src_imm = 0; zext = 0; mode = 0; rw = 0; mr = 0; mw = 0;
        ex_rw = 0; ex_rd = 0; ex_res = 0; wb_rw = 0; wb_rd = 0; wb_res = 0;
    endtask

    initial begin
        clr();
        rst = 1; stall = 0; flush = 0; valid = 1; rs_d = 32'h9; rw = 1; rd_a = 5'd3; op = 6'h3;
        step(); step();
        check("rst_hz", {31'b0, o_hz}, 0);
        check("rst_valid", {31'b0, o_valid}, 0);
        check("rst_srcA", o_a, 0);
        check("rst_srcB", o_b, 0);
        check("rst_ctrl", {29'b0, o_rw, o_mr, o_mw}, 0);
        check("rst_op_rd", {21'b0, o_op, o_rd}, 0);
        rst = 0;

        clr(); valid = 1; rs_a = 1; rs_d = 5; rt_a = 2; rt_d = 7; rd_a = 3; op = 6'b000001; rw = 1;
        step();
        check("add_srcA", o_a, 5);
        check("add_srcB", o_b, 7);
        check("add_rw", {31'b0, o_rw}, 1);
        check("add_op", {26'b0, o_op}, 1);
        check("add_rd", {27'b0, o_rd}, 3);
        check("add_sd", o_sd, 7);

        clr(); valid = 1; rs_a = 1; rs_d = 32'h11; rt_a = 2; rt_d = 32'h22; rd_a = 5;
        step();
        clr();
        ex_rw = 1; ex_rd = 1; ex_res = 32'hAA; wb_rw = 1; wb_rd = 1; wb_res = 32'hBB;
        #1;
`ifdef FWD_EN
        check("fwd_ex_wins", o_a, 32'hAA);
        ex_rw = 0; wb_rd = 2;
        #1;
        check("fwd_wb_rt", o_sd, 32'hBB);
        check("fwd_rs_reg", o_a, 32'h11);
`else
        check("nofwd_srcA", o_a, 32'h11);
        check("nofwd_srcB", o_b, 32'h22);
        valid = 1; rs_a = 1;
        #1;
        check("nofwd_hz_ex", {31'b0, o_hz}, 1);
        ex_rw = 0;
        #1;
        check("nofwd_hz_none", {31'b0, o_hz}, 0);
        valid = 0;
`endif
        clr(); valid = 1; rs_a = 0; rs_d = 32'h33; rt_a = 0; rt_d = 32'h44;
        step();
        clr(); ex_rw = 1; ex_rd = 0; ex_res = 32'hAA; wb_rw = 1; wb_rd = 0; wb_res = 32'hBB;
        #1;
        check("r0_no_fwd_a", o_a, 32'h33);
        check("r0_no_fwd_b", o_b, 32'h44);

        clr(); valid = 1; rs_a = 1; rs_d = 32'h10; imm = 16'hFFFC; src_imm = 1; zext = 0;
        step();
        check("addi_srcA", o_a, 32'h10);
        check("addi_sext", o_b, 32'hFFFFFFFC);
        zext = 1;
        step();
        check("addi_zext", o_b, 32'h0000FFFC);
        clr(); valid = 1; mode = 2'b01; shamt = 4; rt_a = 2; rt_d = 1; rs_d = 32'hDEAD;
        step();
        check("sll_srcA", o_a, 1);
        check("sll_srcB", o_b, 4);
        clr(); valid = 1; mode = 2'b10; rs_a = 3; rs_d = 32'h123; rt_a = 2; rt_d = 32'h80; shamt = 9;
        step();
        check("srlv_srcA", o_a, 32'h80);
        check("srlv_srcB", o_b, 32'h03);
        clr(); valid = 1; mode = 2'b11; rs_d = 9; rt_d = 6; shamt = 7;
        step();
        check("mode11_srcA", o_a, 9);
        check("mode11_srcB", o_b, 6);

        clr(); valid = 0; rw = 1; mr = 1; mw = 1; rd_a = 6;
        step();
        check("inv_valid", {31'b0, o_valid}, 0);
        check("inv_ctrl", {29'b0, o_rw, o_mr, o_mw}, 0);

        clr(); valid = 1; mr = 1; rw = 1; rd_a = 0;
        step();
        clr(); valid = 1; rt_a = 0; rs_a = 0;
        #1;
        check("lw_r0_hz", {31'b0, o_hz}, 0);

        clr(); valid = 1; mr = 1; rw = 1; rd_a = 4; rs_a = 1;
        step();
        clr(); valid = 0; rt_a = 4; rs_a = 6;
        #1;
        check("lw_idle_hz", {31'b0, o_hz}, 0);
        valid = 1;
        #1;
        check("lw_use_hz", {31'b0, o_hz}, 1);
        flush = o_hz;
        step();
        flush = 0;
        check("bubble_valid", {31'b0, o_valid}, 0);
        check("bubble_mr", {31'b0, o_mr}, 0);
        check("bubble_hz", {31'b0, o_hz}, 0);

        clr(); valid = 1; rs_d = 32'h55; rt_d = 32'h66; rd_a = 7; op = 6'h2A; rw = 1; mw = 1;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            clr(); valid = i[0]; rs_d = 32'h100 + i; rt_d = 32'h200 + i; rd_a = 5'(i + 10); op = 6'(i);
            step();
            check("stall_srcA", o_a, 32'h55);
            check("stall_srcB", o_b, 32'h66);
            check("stall_oprd", {21'b0, o_op, o_rd}, {21'b0, 6'h2A, 5'd7});
            check("stall_ctrl", {28'b0, o_valid, o_rw, o_mr, o_mw}, 32'b1101);
        end
        flush = 1;
        step();
        flush = 0;
        check("flush_over_stall", {31'b0, o_valid}, 0);
        clr(); valid = 1; rs_d = 32'h77; rw = 1; stall = 0;
        step();
        check("reload_srcA", o_a, 32'h77);
        stall = 1; rst = 1;
        step();
        check("rst_stall_valid", {31'b0, o_valid}, 0);
        check("rst_stall_srcA", o_a, 0);
        check("rst_stall_rw", {31'b0, o_rw}, 0);
        rst = 0; stall = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
